// File: rtl/jk_pkg.sv
// Shared JK flip-flop command encoding and next-state function.
// Used by jk_cell and jk_mod_counter.
package jk_pkg;

    // Encoded as {J,K}
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r;
        r = q;
        case (jk_cmd_e'({j, k}))
            JK_HOLD:   r = q;
            JK_RESET:  r = 1'b0;
            JK_SET:    r = 1'b1;
            JK_TOGGLE: r = ~q;
            default:   r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single edge-triggered JK bit. No internal reset: the parent clears it by
// driving J=0, K=1, which yields a known 0 even from an unknown Q.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_
);

    always_ff @(posedge clk) begin
        Q <= jk_next(Q, J, K);
    end

    assign Q_ = ~Q;

endmodule

// File: rtl/jk_mod_counter.sv
// Synchronous modulo-N up/down counter built from WIDTH jk_cell instances.
// Define JK_MOD_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             tc,
    output logic             wrap
);

    generate
        if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
            $fatal(1, "jk_mod_counter: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_q_eff;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;
    logic             r_wrap;

    // Out-of-range states behave as the top of the range.
    assign w_q_eff   = (w_q > MAX_Q) ? MAX_Q : w_q;
    assign w_at_max  = (w_q_eff == MAX_Q);
    assign w_at_zero = (w_q_eff == '0);
    assign w_tc      = en & ((up & w_at_max) | (~up & w_at_zero));

    always_comb begin
        w_nxt = w_q;
        if (load) begin
            w_nxt = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (en) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
            if (w_tc)
                w_nxt = w_q_eff;
            else if (up)
                w_nxt = w_q_eff + WIDTH'(1);
            else
                w_nxt = w_q_eff - WIDTH'(1);
`else
            if (up)
                w_nxt = w_at_max ? '0 : w_q_eff + WIDTH'(1);
            else
                w_nxt = w_at_zero ? MAX_Q : w_q_eff - WIDTH'(1);
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            // Reset forces K on every cell so the cleared state never depends on Q.
            assign w_j[gi] = rst ? 1'b0 : ( w_nxt[gi] & ~w_q[gi]);
            assign w_k[gi] = rst ? 1'b1 : (~w_nxt[gi] &  w_q[gi]);

            jk_cell u_cell (
                .clk (clk),
                .J   (w_j[gi]),
                .K   (w_k[gi]),
                .Q   (w_q[gi]),
                .Q_  (w_qn[gi])
            );
        end
    endgenerate

    // In saturate builds tc while enabled means the count was blocked.
    always_ff @(posedge clk) begin
        if (rst)
            r_wrap <= 1'b0;
        else if (load)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_tc;
    end

    assign q    = w_q;
    assign q_n  = w_qn;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: WIDTH=4/MODULUS=10 main instance,
// plus a MODULUS=16 instance for the limit behaviour (saturate or wrap per build).
module tb_jk_mod_counter;

    typedef struct {
        logic [3:0] q;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q, q_n;
    logic       tc, wrap;

    logic       b_rst = 1'b1, b_en = 1'b0, b_up = 1'b0, b_load = 1'b0;
    logic [3:0] b_load_val = 4'd0;
    logic [3:0] b_q, b_q_n;
    logic       b_tc, b_wrap;

    int   tests_run = 0;
    int   failures  = 0;
    exp_t sb[$];
    logic [3:0] m_q;
    logic       exp_tc;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q), .q_n(q_n), .tc(tc), .wrap(wrap)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load), .load_val(b_load_val),
        .q(b_q), .q_n(b_q_n), .tc(b_tc), .wrap(b_wrap)
    );

    // Drive one cycle of inputs on the main DUT, push the modelled result, then
    // step past the rising edge. exp_tc holds the modelled combinational tc.
    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv);
        exp_t x;
        rst = r; en = e; up = u; load = l; load_val = lv;
        exp_tc = e && ((u && m_q == 4'd9) || (!u && m_q == 4'd0));
        if (r) begin
            x.q = 4'd0; x.wrap = 1'b0;
        end else if (l) begin
            x.q = (lv > 4'd9) ? 4'd9 : lv; x.wrap = 1'b0;
        end else if (e) begin
            if (u) x.q = (m_q == 4'd9) ? 4'd0 : m_q + 4'd1;
            else   x.q = (m_q == 4'd0) ? 4'd9 : m_q - 4'd1;
            x.wrap = exp_tc;
        end else begin
            x.q = m_q; x.wrap = 1'b0;
        end
        sb.push_back(x);
        #2;
    endtask

    task automatic finish_edge();
        @(posedge clk);
        #1;
        m_q = sb[$].q;
    endtask

    task automatic test_reset();
        exp_t x;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        finish_edge();
        x = sb.pop_front();
        tests_run++;
        if ($isunknown(q) || q !== x.q || q_n !== 4'hF || wrap !== x.wrap) begin
            failures++;
            $display("FAIL reset: q=%h q_n=%h wrap=%b required q=%h q_n=F wrap=%b", q, q_n, wrap, x.q, x.wrap);
        end
        $display("[TB] reset: q=%h q_n=%h wrap=%b", q, q_n, wrap);
    endtask

    task automatic test_count_up();
        exp_t x;
        logic t;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            t = tc;
            finish_edge();
            x = sb.pop_front();
            tests_run++;
            if (q !== x.q || q_n !== ~x.q || wrap !== x.wrap || t !== exp_tc) begin
                failures++;
                $display("FAIL count_up[%0d]: q=%h q_n=%h wrap=%b tc=%b required q=%h wrap=%b tc=%b",
                         i, q, q_n, wrap, t, x.q, x.wrap, exp_tc);
            end
            $display("[TB] count_up[%0d]: q=%0d wrap=%b tc=%b", i, q, wrap, t);
        end
    endtask

    task automatic test_load();
        exp_t x;
        logic [3:0] vals[2] = '{4'd7, 4'd13};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, vals[i]);
            finish_edge();
            x = sb.pop_front();
            tests_run++;
            if (q !== x.q || wrap !== x.wrap) begin
                failures++;
                $display("FAIL load[%0d]: q=%0d wrap=%b required q=%0d wrap=%b", i, q, wrap, x.q, x.wrap);
            end
            $display("[TB] load val=%0d: q=%0d wrap=%b", vals[i], q, wrap);
        end
    endtask

    task automatic test_down_and_direction();
        exp_t x;
        logic t;
        // load 0, step down (wrap to 9), load 5, then alternate direction
        logic       l_tab[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       u_tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] lv_tab[7] = '{4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, u_tab[i], l_tab[i], lv_tab[i]);
            t = tc;
            finish_edge();
            x = sb.pop_front();
            tests_run++;
            if (q !== x.q || wrap !== x.wrap || t !== exp_tc) begin
                failures++;
                $display("FAIL down_dir[%0d]: q=%0d wrap=%b tc=%b required q=%0d wrap=%b tc=%b",
                         i, q, wrap, t, x.q, x.wrap, exp_tc);
            end
            $display("[TB] down_dir[%0d]: q=%0d wrap=%b tc=%b", i, q, wrap, t);
        end
    endtask

    task automatic test_reset_priority_and_hold();
        exp_t x;
        logic t;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd6);
        finish_edge();
        x = sb.pop_front();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
        finish_edge();
        x = sb.pop_front();
        tests_run++;
        if (q !== x.q || wrap !== x.wrap) begin
            failures++;
            $display("FAIL rst_priority: q=%0d wrap=%b required q=%0d wrap=%b", q, wrap, x.q, x.wrap);
        end
        $display("[TB] rst_priority: q=%0d wrap=%b", q, wrap);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
            t = tc;
            finish_edge();
            x = sb.pop_front();
            tests_run++;
            if (q !== x.q || wrap !== x.wrap || t !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: q=%0d wrap=%b tc=%b required q=%0d wrap=%b tc=0",
                         i, q, wrap, t, x.q, x.wrap);
            end
            $display("[TB] hold[%0d]: q=%0d wrap=%b", i, q, wrap);
        end
    endtask

    task automatic test_limit16();
        exp_t x;
        exp_t want;
        exp_t q16[$];
        b_rst = 1'b0; b_load = 1'b1; b_load_val = 4'd14; b_en = 1'b0; b_up = 1'b1;
        @(posedge clk); #1;
        b_load = 1'b0; b_en = 1'b1;
`ifdef JK_MOD_COUNTER_SATURATE_EN
        want.q = 4'd15; want.wrap = 1'b0; q16.push_back(want);
        want.q = 4'd15; want.wrap = 1'b1; q16.push_back(want);
        want.q = 4'd15; want.wrap = 1'b1; q16.push_back(want);
`else
        want.q = 4'd15; want.wrap = 1'b0; q16.push_back(want);
        want.q = 4'd0;  want.wrap = 1'b1; q16.push_back(want);
        want.q = 4'd1;  want.wrap = 1'b0; q16.push_back(want);
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            x = q16.pop_front();
            tests_run++;
            if (b_q !== x.q || b_wrap !== x.wrap) begin
                failures++;
                $display("FAIL limit16[%0d]: q=%0d wrap=%b required q=%0d wrap=%b", i, b_q, b_wrap, x.q, x.wrap);
            end
            $display("[TB] limit16[%0d]: q=%0d wrap=%b", i, b_q, b_wrap);
        end
        b_en = 1'b0;
    endtask

    initial begin
        m_q = 4'd0;
        @(posedge clk); #1;
        b_rst = 1'b1;
        test_reset();
        test_count_up();
        test_load();
        test_down_and_direction();
        test_reset_priority_and_hold();
        test_limit16();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
